fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared core package: fetch FSM states, PC-select encodings and small sizing helpers.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'b00,
        FETCH_WAIT    = 2'b01,
        FETCH_DISCARD = 2'b10
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_SEL_SEQ    = 2'b00,
        PC_SEL_BRANCH = 2'b01,
        PC_SEL_JAL    = 2'b10,
        PC_SEL_JALR   = 2'b11
    } pc_sel_t;

    localparam int unsigned INSTR_BYTES = 4;

    // Occupancy counter width able to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH-entry FIFO of {pc, instr} pairs with flush.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic [2*DWIDTH-1:0]           din,
    output logic [2*DWIDTH-1:0]           dout,
    output logic [cnt_width(DEPTH)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [2*DWIDTH-1:0] mem [DEPTH];

    // Flush overrides push and pop; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request, redirect-aware response
// dropping, and a small buffer feeding decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] pc_value,
    input  logic              redirect,
    output logic              pc_en,
    output logic              mem_req,
    output logic [DWIDTH-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              if_valid,
    output logic [DWIDTH-1:0] if_instr,
    output logic [DWIDTH-1:0] if_pc,
    input  logic              if_ready
);

    localparam int unsigned CW = cnt_width(DEPTH);

    fetch_state_t        state;
    fetch_state_t        state_nxt;
    logic [DWIDTH-1:0]   req_pc;
    logic [CW-1:0]       fifo_count;
    logic                push;
    logic                pop;
    logic [2*DWIDTH-1:0] head;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= FETCH_IDLE;
            req_pc <= '0;
        end else begin
            state <= state_nxt;
            if (mem_req) begin
                req_pc <= pc_value;
            end
        end
    end

    // Issue only when a push can never be blocked; responses after a redirect are dropped.
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        push      = 1'b0;
        case (state)
            FETCH_IDLE: begin
                if (reset && !redirect && (fifo_count < CW'(DEPTH))) begin
                    mem_req   = 1'b1;
                    state_nxt = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (redirect) begin
                    state_nxt = mem_rvalid ? FETCH_IDLE : FETCH_DISCARD;
                end else if (mem_rvalid) begin
                    push      = 1'b1;
                    state_nxt = FETCH_IDLE;
                end
            end
            FETCH_DISCARD: begin
                if (mem_rvalid) begin
                    state_nxt = FETCH_IDLE;
                end
            end
            default: state_nxt = FETCH_IDLE;
        endcase
    end

    assign pc_en    = mem_req;
    assign mem_addr = pc_value;
    assign if_valid = (fifo_count != '0);
    assign pop      = if_valid && if_ready;
    assign if_pc    = head[2*DWIDTH-1:DWIDTH];
    assign if_instr = head[DWIDTH-1:0];

    fetch_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   ({req_pc, mem_rdata}),
        .dout  (head),
        .count (fifo_count)
    );

endmodule
